// File: rtl/alu_sequencer.sv
// Execute-stage controller for the combinational Z8 ALU: latches decoder operands,
// sequences byte ops and two-step word ops (INCW/DECW), owns the FLAGS register.
module alu_sequencer #(
    parameter logic [7:0] FLAGS_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [4:0] mode,
    input  logic [7:0] op_a,
    input  logic [7:0] op_a_hi,
    input  logic [7:0] op_b,
    input  logic       flags_we,
    input  logic [7:0] flags_wdata,
    output logic [4:0] alu_mode,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [7:0] alu_flags,
    input  logic [7:0] alu_out,
    input  logic [7:0] alu_out_flags,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic [7:0] result_hi,
    output logic       wr_lo,
    output logic       wr_hi,
    output logic [7:0] flags
);

    // Two-operand (ALU2_*) and single-operand (ALU1_*) mode codes of the ALU.
    localparam logic [4:0] ALU2_ADD          = 5'h00;
    localparam logic [4:0] ALU2_ADC          = 5'h01;
    localparam logic [4:0] ALU2_SUB          = 5'h02;
    localparam logic [4:0] ALU2_SBC          = 5'h03;
    localparam logic [4:0] ALU2_OR           = 5'h04;
    localparam logic [4:0] ALU2_AND          = 5'h05;
    localparam logic [4:0] ALU2_TCM          = 5'h06;
    localparam logic [4:0] ALU2_TM           = 5'h07;
    localparam logic [4:0] ALU2_CP           = 5'h08;
    localparam logic [4:0] ALU2_XOR          = 5'h09;
    localparam logic [4:0] ALU1_RLC          = 5'h10;
    localparam logic [4:0] ALU1_INC          = 5'h11;
    localparam logic [4:0] ALU1_DEC          = 5'h12;
    localparam logic [4:0] ALU1_DA           = 5'h13;
    localparam logic [4:0] ALU1_COM          = 5'h14;
    localparam logic [4:0] ALU1_LD           = 5'h15;
    localparam logic [4:0] ALU1_CLR          = 5'h16;
    localparam logic [4:0] ALU1_RL           = 5'h17;
    localparam logic [4:0] ALU1_INCW_UPPER_0 = 5'h18;
    localparam logic [4:0] ALU1_INCW         = 5'h19;
    localparam logic [4:0] ALU1_DECW         = 5'h1A;

    typedef enum logic [1:0] {
        IDLE,
        EXEC_LO,
        EXEC_HI
    } state_t;

    state_t     state;
    logic [4:0] mode_q;
    logic [7:0] a_q;
    logic [7:0] a_hi_q;
    logic [7:0] b_q;
    logic [7:0] tmp_flags;
    logic       carry_q;
    logic [7:0] flags_q;

    logic       is_word;
    logic       writes_lo;

    assign flags = flags_q;

    // NOTE: every output of an always_comb gets a default first, so no path leaves a latch.
    always_comb begin
        is_word   = (mode_q == ALU1_INCW) || (mode_q == ALU1_DECW);
        writes_lo = !((mode_q == ALU2_CP) || (mode_q == ALU2_TM) || (mode_q == ALU2_TCM));
        alu_mode  = ALU1_LD;
        alu_a     = 8'h00;
        alu_b     = 8'h00;
        alu_flags = flags_q;
        case (state)
            EXEC_LO: begin
                alu_mode = is_word ? (mode_q & 5'b10111) : mode_q;
                alu_a    = a_q;
                alu_b    = b_q;
            end
            EXEC_HI: begin
                // Upper byte only increments/decrements when the low byte wrapped.
                alu_mode  = carry_q ? mode_q : ALU1_INCW_UPPER_0;
                alu_a     = a_hi_q;
                alu_flags = tmp_flags;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; later ones in the block win.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            mode_q    <= 5'h00;
            a_q       <= 8'h00;
            a_hi_q    <= 8'h00;
            b_q       <= 8'h00;
            tmp_flags <= 8'h00;
            carry_q   <= 1'b0;
            flags_q   <= FLAGS_RESET;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_lo     <= 1'b0;
            wr_hi     <= 1'b0;
            result    <= 8'h00;
            result_hi <= 8'h00;
        end else begin
            done  <= 1'b0;
            wr_lo <= 1'b0;
            wr_hi <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        a_q    <= op_a;
                        a_hi_q <= op_a_hi;
                        b_q    <= op_b;
                        busy   <= 1'b1;
                        state  <= EXEC_LO;
                    end
                end
                EXEC_LO: begin
                    result <= alu_out;
                    if (is_word) begin
                        tmp_flags <= alu_out_flags;
                        carry_q   <= (mode_q == ALU1_INCW) ? (alu_out == 8'h00) : (a_q == 8'h00);
                        state     <= EXEC_HI;
                    end else begin
                        flags_q <= alu_out_flags;
                        done    <= 1'b1;
                        wr_lo   <= writes_lo;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                EXEC_HI: begin
                    result_hi <= alu_out;
                    flags_q   <= alu_out_flags;
                    done      <= 1'b1;
                    wr_lo     <= 1'b1;
                    wr_hi     <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // External write has the last word over any ALU flag capture.
            if (flags_we) flags_q <= flags_wdata;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural Z8 ALU on the ALU ports,
// directed scenarios followed by randomized byte/word operations.
module tb_alu_sequencer;

    localparam logic [4:0] ADD = 5'h00, ADC = 5'h01, SUB = 5'h02, SBC = 5'h03;
    localparam logic [4:0] OR_ = 5'h04, AND_ = 5'h05, TCM = 5'h06, TM = 5'h07;
    localparam logic [4:0] CP = 5'h08, XOR_ = 5'h09;
    localparam logic [4:0] INC = 5'h11, DEC = 5'h12, COM = 5'h14, LD = 5'h15, CLR = 5'h16;
    localparam logic [4:0] UPPER0 = 5'h18, INCW = 5'h19, DECW = 5'h1A;
    localparam int FC = 7, FZ = 6, FS = 5, FV = 4, FD = 3, FH = 2;
    localparam logic [7:0] F_RST = 8'h00;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] mode = 5'h00;
    logic [7:0] op_a = 8'h00, op_a_hi = 8'h00, op_b = 8'h00;
    logic       flags_we = 1'b0;
    logic [7:0] flags_wdata = 8'h00;
    logic [4:0] alu_mode;
    logic [7:0] alu_a, alu_b, alu_flags, alu_out, alu_out_flags;
    logic       busy, done, wr_lo, wr_hi;
    logic [7:0] result, result_hi, flags;

    int         n_vec = 0;
    int         n_miss = 0;
    logic [7:0] m_flags;

    always #5 clk = ~clk;

    alu_sequencer #(.FLAGS_RESET(F_RST)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .op_a(op_a), .op_a_hi(op_a_hi), .op_b(op_b),
        .flags_we(flags_we), .flags_wdata(flags_wdata),
        .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b), .alu_flags(alu_flags),
        .alu_out(alu_out), .alu_out_flags(alu_out_flags),
        .busy(busy), .done(done), .result(result), .result_hi(result_hi),
        .wr_lo(wr_lo), .wr_hi(wr_hi), .flags(flags)
    );

    // Behavioural ALU: returns {flags, out}. Flags: C7 Z6 S5 V4 D3 H2.
    function automatic logic [15:0] alu_fn(input logic [4:0] m, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] f);
        logic [7:0] r;
        logic [7:0] nf;
        logic [8:0] w;
        logic       c;
        logic       zs;
        r  = a;
        nf = f;
        zs = 1'b1;
        c  = 1'b0;
        case (m)
            ADD, ADC: begin
                c  = (m == ADC) ? f[FC] : 1'b0;
                w  = {1'b0, a} + {1'b0, b} + {8'h00, c};
                r  = w[7:0];
                nf[FC] = w[8];
                nf[FH] = ({1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'h0, c}) > 5'h0F;
                nf[FV] = (a[7] == b[7]) && (r[7] != a[7]);
                nf[FD] = 1'b0;
            end
            SUB, SBC, CP: begin
                c  = (m == SBC) ? f[FC] : 1'b0;
                w  = {1'b0, a} - {1'b0, b} - {8'h00, c};
                r  = w[7:0];
                nf[FC] = w[8];
                nf[FV] = (a[7] != b[7]) && (r[7] != a[7]);
                if (m != CP) begin
                    nf[FD] = 1'b1;
                    nf[FH] = {1'b0, a[3:0]} < ({1'b0, b[3:0]} + {4'h0, c});
                end
            end
            AND_, TM: begin r = a & b;  nf[FV] = 1'b0; end
            OR_:      begin r = a | b;  nf[FV] = 1'b0; end
            XOR_:     begin r = a ^ b;  nf[FV] = 1'b0; end
            TCM:      begin r = ~a & b; nf[FV] = 1'b0; end
            COM:      begin r = ~a;     nf[FV] = 1'b0; end
            INC:      begin r = a + 8'd1; nf[FV] = (a == 8'h7F); end
            DEC:      begin r = a - 8'd1; nf[FV] = (a == 8'h80); end
            INCW, DECW, UPPER0: begin
                r  = (m == INCW) ? a + 8'd1 : (m == DECW) ? a - 8'd1 : a;
                nf[FV] = (m == INCW) ? (a == 8'h7F) : (m == DECW) ? (a == 8'h80) : 1'b0;
                nf[FZ] = f[FZ] && (r == 8'h00);
                nf[FS] = r[7];
                zs = 1'b0;
            end
            CLR:     begin r = 8'h00; zs = 1'b0; end
            default: begin r = a; zs = 1'b0; end
        endcase
        if (zs) begin
            nf[FZ] = (r == 8'h00);
            nf[FS] = r[7];
        end
        return {nf, r};
    endfunction

    assign {alu_out_flags, alu_out} = alu_fn(alu_mode, alu_a, alu_b, alu_flags);

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one operation at the current time and returns at the done cycle (+1).
    task automatic run_op(input logic [4:0] m, input logic [7:0] a, input logic [7:0] ahi,
                          input logic [7:0] b, input logic poke, input logic inject,
                          input logic [7:0] inj_val);
        logic        word_op;
        logic        wl;
        logic        carry;
        logic [4:0]  lm;
        logic [4:0]  hm;
        logic [15:0] lo_r;
        logic [15:0] hi_r;
        logic [15:0] wv;
        logic [7:0]  ef;
        word_op = (m == INCW) || (m == DECW);
        mode = m; op_a = a; op_a_hi = ahi; op_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mode = 5'($urandom); op_a = 8'($urandom); op_a_hi = 8'($urandom); op_b = 8'($urandom);
        check("accept_busy", 16'(busy), 16'd1);
        check("accept_done", 16'(done), 16'd0);
        check("accept_wr_lo", 16'(wr_lo), 16'd0);
        if (!word_op) begin
            check("lo_mode", 16'(alu_mode), 16'(m));
            check("lo_a", 16'(alu_a), 16'(a));
            check("lo_b", 16'(alu_b), 16'(b));
            lo_r = alu_fn(m, a, b, m_flags);
            wl = !(m == CP || m == TM || m == TCM);
            @(posedge clk); #1;
            check("byte_done", 16'(done), 16'd1);
            check("byte_busy", 16'(busy), 16'd0);
            check("byte_result", 16'(result), 16'(lo_r[7:0]));
            check("byte_wr_lo", 16'(wr_lo), 16'(wl));
            check("byte_wr_hi", 16'(wr_hi), 16'd0);
            check("byte_flags", 16'(flags), 16'(lo_r[15:8]));
            m_flags = lo_r[15:8];
        end else begin
            wv    = (m == INCW) ? {ahi, a} + 16'd1 : {ahi, a} - 16'd1;
            carry = (m == INCW) ? (a == 8'hFF) : (a == 8'h00);
            lm    = (m == INCW) ? INC : DEC;
            check("wlo_mode", 16'(alu_mode), 16'(lm));
            check("wlo_a", 16'(alu_a), 16'(a));
            lo_r = alu_fn(lm, a, 8'h00, m_flags);
            if (poke) begin
                start = 1'b1; mode = ADD;
            end
            @(posedge clk); #1;
            start = 1'b0;
            check("whi_busy", 16'(busy), 16'd1);
            check("whi_done", 16'(done), 16'd0);
            check("whi_result", 16'(result), 16'(wv[7:0]));
            check("whi_flags_hold", 16'(flags), 16'(m_flags));
            hm = carry ? m : UPPER0;
            check("whi_mode", 16'(alu_mode), 16'(hm));
            check("whi_a", 16'(alu_a), 16'(ahi));
            check("whi_alu_flags", 16'(alu_flags), 16'(lo_r[15:8]));
            hi_r = alu_fn(hm, ahi, 8'h00, lo_r[15:8]);
            if (inject) begin
                flags_we = 1'b1; flags_wdata = inj_val;
            end
            @(posedge clk); #1;
            flags_we = 1'b0;
            ef = inject ? inj_val : hi_r[15:8];
            check("word_done", 16'(done), 16'd1);
            check("word_busy", 16'(busy), 16'd0);
            check("word_result", 16'(result), 16'(wv[7:0]));
            check("word_result_hi", 16'(result_hi), 16'(wv[15:8]));
            check("word_wr_lo", 16'(wr_lo), 16'd1);
            check("word_wr_hi", 16'(wr_hi), 16'd1);
            check("word_flags", 16'(flags), 16'(ef));
            m_flags = ef;
        end
    endtask

    task automatic load_flags(input logic [7:0] v);
        flags_we = 1'b1; flags_wdata = v;
        @(posedge clk); #1;
        flags_we = 1'b0;
        check("flags_load", 16'(flags), 16'(v));
        m_flags = v;
    endtask

    initial begin
        logic [4:0] modes [17];
        int         dones;
        logic [4:0] m;
        logic [7:0] a;
        logic [7:0] ahi;
        modes = '{ADD, ADC, SUB, SBC, OR_, AND_, TCM, TM, CP, XOR_, INC, DEC, COM, CLR, LD, INCW, DECW};
        m_flags = F_RST;

        #12;
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_wr", 16'({wr_lo, wr_hi}), 16'd0);
        check("rst_result", 16'({result_hi, result}), 16'd0);
        check("rst_flags", 16'(flags), 16'(F_RST));
        check("idle_alu_mode", 16'(alu_mode), 16'(LD));
        check("idle_alu_ab", 16'({alu_a, alu_b}), 16'd0);
        check("idle_alu_flags", 16'(alu_flags), 16'(flags));
        reset_n = 1'b1;

        run_op(ADD, 8'h7F, 8'h00, 8'h01, 1'b0, 1'b0, 8'h00);
        check("add_result", 16'(result), 16'h0080);
        check("add_flags", 16'(flags), 16'h0034);

        run_op(INCW, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        check("incw_word", 16'({result_hi, result}), 16'h0100);
        check("incw_z", 16'(flags[FZ]), 16'd0);

        run_op(DECW, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        check("decw1_word", 16'({result_hi, result}), 16'h0000);
        check("decw1_zv", 16'({flags[FZ], flags[FV]}), 16'b10);

        run_op(DECW, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00);
        check("decw2_word", 16'({result_hi, result}), 16'h00FF);
        check("decw2_z", 16'(flags[FZ]), 16'd0);

        run_op(CP, 8'h10, 8'h00, 8'h20, 1'b0, 1'b0, 8'h00);
        check("cp_result", 16'(result), 16'h00F0);
        check("cp_wr_lo", 16'({done, wr_lo}), 16'b10);
        check("cp_czs", 16'({flags[FC], flags[FZ], flags[FS]}), 16'b101);

        run_op(INCW, 8'hFF, 8'h12, 8'h00, 1'b1, 1'b1, 8'hA5);
        check("inj_flags", 16'(flags), 16'h00A5);
        check("inj_result_hi", 16'(result_hi), 16'h0013);
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("poke_no_extra_done", 16'(dones), 16'd0);

        mode = INCW; op_a = 8'hFF; op_a_hi = 8'h00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("pre_abort_busy", 16'(busy), 16'd1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", 16'(busy), 16'd0);
        check("abort_flags", 16'(flags), 16'(F_RST));
        check("abort_outs", 16'({result_hi, result}), 16'd0);
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done || wr_lo || wr_hi) dones++;
        end
        check("abort_no_done", 16'(dones), 16'd0);
        reset_n = 1'b1;
        m_flags = F_RST;
        run_op(ADD, 8'h7F, 8'h00, 8'h01, 1'b0, 1'b0, 8'h00);
        check("post_abort_add", 16'({flags, result}), 16'h3480);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(3) == 0) load_flags(8'($urandom));
            m = modes[$urandom_range(16)];
            case ($urandom_range(3))
                0:       a = 8'hFF;
                1:       a = 8'h00;
                default: a = 8'($urandom);
            endcase
            ahi = ($urandom_range(3) == 0) ? 8'h7F : 8'($urandom);
            run_op(m, a, ahi, 8'($urandom), 1'b0, ($urandom_range(4) == 0), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Execute-stage controller that sits directly upstream of the combinational Z8 ALU: it latches operands from the decoder, drives the ALU mode/operand/flag inputs, and captures the ALU result and flags.
- Owns the architectural FLAGS register.
- Sequences two-byte word operations (INCW/DECW) as a low-byte step followed by a high-byte step. It picks the upper-byte ALU mode from the low-byte carry or borrow.
- Reports results with write-enables to the register-file write-back stage.

Parameters:
- FLAGS_RESET, 8'h00, value loaded into the FLAGS register on reset.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request to execute one operation; sampled only in IDLE
- mode  in  5  ALU mode code (ALU1_*/ALU2_* from alu.vh)
- op_a  in  8  operand A; low byte for word ops
- op_a_hi  in  8  high byte of operand A for word ops; ignored otherwise
- op_b  in  8  operand B
- flags_we  in  1  external FLAGS write strobe
- flags_wdata  in  8  external FLAGS write data
- alu_mode  out  5  to ALU mode
- alu_a  out  8  to ALU a
- alu_b  out  8  to ALU b
- alu_flags  out  8  to ALU flags
- alu_out  in  8  from ALU out
- alu_out_flags  in  8  from ALU outFlags
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; result, result_hi, wr_lo and wr_hi are valid while it is high
- result  out  8  low or byte result
- result_hi  out  8  high result byte (word ops only)
- wr_lo  out  1  write-back enable for result, qualified by done
- wr_hi  out  1  write-back enable for result_hi, qualified by done
- flags  out  8  architectural FLAGS register

Behaviour:
- Reset (async, reset_n=0): state IDLE; busy=0; done=0; wr_lo=0; wr_hi=0; result=0; result_hi=0; flags=FLAGS_RESET; all internal latches cleared. Reset mid-operation aborts the operation with no write-back and no done.
- States: IDLE, EXEC_LO, EXEC_HI.
- IDLE:
  - ALU driven with mode=ALU1_LD, a=0, b=0, alu_flags=flags.
  - On start=1 at edge N: latch mode, op_a, op_a_hi, op_b. Set busy=1. Go to EXEC_LO.
- Word op: latched mode is ALU1_INCW or ALU1_DECW.
- EXEC_LO:
  - alu_a=op_a, alu_b=op_b, alu_flags=flags.
  - alu_mode is the latched mode with bit 3 cleared for word ops (INCW->INC, DECW->DEC); otherwise the latched mode unchanged.
  - Byte op, at edge N+1: result<=alu_out; flags<=alu_out_flags; done<=1; busy<=0; wr_lo<=1 except for ALU2_CP, ALU2_TM and ALU2_TCM (wr_lo<=0); wr_hi<=0. Go to IDLE.
  - Word op, at edge N+1: result<=alu_out; tmp_flags<=alu_out_flags (flags register not updated). Record carry_out: for INCW, alu_out==8'h00; for DECW, op_a==8'h00. Go to EXEC_HI.
- EXEC_HI:
  - alu_a=op_a_hi, alu_b=0, alu_flags=tmp_flags.
  - alu_mode is chosen as follows:
    - INCW: ALU1_INCW if carry_out, else ALU1_INCW_UPPER_0.
    - DECW: ALU1_DECW if carry_out, else ALU1_INCW_UPPER_0 (pass-through).
  - At edge N+2: result_hi<=alu_out; flags<=alu_out_flags; done<=1; wr_lo<=1; wr_hi<=1; busy<=0. Go to IDLE.
- done, wr_lo and wr_hi clear on the edge after they were set.
- start is ignored while busy=1, with no queueing. start is accepted in the cycle done is high, because the state is already IDLE.
- Latency from the accepting edge to done: byte op 1 edge, word op 2 edges. Maximum throughput is one byte op per 2 cycles.
- flags_we=1:
  - Loads flags<=flags_wdata at that edge in any state.
  - If it coincides with an ALU flag capture, flags_wdata wins.
  - It does not alter tmp_flags, so an in-flight EXEC_HI step still uses the low-step flags.
- Operand latches are stable from acceptance until the next start; changes to the inputs while busy have no effect.

Test Plan:
- ADD: mode=ALU2_ADD, a=8'h7F, b=8'h01, flags=0 -> done at edge N+1; result=8'h80, wr_lo=1; flags S=1, V=1, H=1, Z=0, C=0, D=0.
- INCW: {hi,lo}=16'h00FF -> low step ALU1_INC, upper step ALU1_INCW; result=8'h00, result_hi=8'h01, wr_lo=1, wr_hi=1, Z=0, done at edge N+2.
- DECW: 16'h0001 -> no borrow, upper step ALU1_INCW_UPPER_0; result=8'h00, result_hi=8'h00, Z=1, V=0. DECW: 16'h0100 -> result=8'hFF, result_hi=8'h00, Z=0.
- CP: a=8'h10, b=8'h20 -> wr_lo=0 with done=1; flags C=1, S=1, Z=0; result=8'hF0.
- start pulsed in EXEC_LO of an INCW -> ignored, exactly one done; flags_we=1 with flags_wdata=8'hA5 on the EXEC_HI capture edge -> flags=8'hA5, result_hi still written.
- reset_n low during EXEC_HI -> busy=0, done never pulses, flags=FLAGS_RESET, outputs zero; a fresh ADD afterwards completes normally.
